// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl
// Purpose  : Sequencing controller for the HH:MM:SS BCD clock datapath. In
//            RUN it advances time on each TICK_1HZ. BTN_MODE steps it through
//            three set states (hours, minutes, seconds). In those states the
//            time is frozen and BTN_UP/BTN_DOWN edit the selected field. If no
//            button arrives within IDLE_TICKS seconds, it returns to RUN.
// Ports    : CLK        in   1   system clock, rising edge
//            RESET      in   1   asynchronous active-low reset
//            TICK_1HZ   in   1   one-cycle pulse per second
//            BTN_MODE   in   1   one-cycle pulse, advance mode
//            BTN_UP     in   1   one-cycle pulse, increment selected field
//            BTN_DOWN   in   1   one-cycle pulse, decrement selected field
//            TIME_DATA  out  32  {8'h00, HH, MM, SS}, two BCD digits each
//            EDIT_SEL   out  2   00 RUN, 01 SET_HH, 10 SET_MM, 11 SET_SS
//            DAY_PULSE  out  1   one-cycle pulse on midnight rollover
// Revision : 1.0 - initial release
// ============================================================================
module time_set_ctrl #(
    parameter int          HOUR_MAX   = 23,
    parameter logic [7:0]  INIT_HH    = 8'h12,
    parameter logic [7:0]  INIT_MM    = 8'h00,
    parameter logic [7:0]  INIT_SS    = 8'h00,
    parameter int          IDLE_TICKS = 10
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TICK_1HZ,
    input  logic        BTN_MODE,
    input  logic        BTN_UP,
    input  logic        BTN_DOWN,
    output logic [31:0] TIME_DATA,
    output logic [1:0]  EDIT_SEL,
    output logic        DAY_PULSE
);

    // State encoding doubles as the EDIT_SEL output code.
    localparam logic [1:0] c_ST_RUN    = 2'b00;
    localparam logic [1:0] c_ST_SET_HH = 2'b01;
    localparam logic [1:0] c_ST_SET_MM = 2'b10;
    localparam logic [1:0] c_ST_SET_SS = 2'b11;

    // Upper limit of each field, in BCD form.
    localparam logic [7:0] c_HOUR_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
    localparam logic [7:0] c_SIX_MAX  = 8'h59;
    localparam logic [7:0] c_IDLE     = 8'(IDLE_TICKS);

    logic [1:0] state_q, state_d;
    logic [7:0] hh_q, hh_d;
    logic [7:0] mm_q, mm_d;
    logic [7:0] ss_q, ss_d;
    logic [7:0] idle_q, idle_d;
    logic       day_q, day_d;

    logic       w_any_btn;
    logic       w_edit_up;
    logic       w_edit_dn;

    // Increment a two-digit BCD value, wrapping max -> 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
        logic [7:0] r;
        if (v == maxv) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Decrement a two-digit BCD value, wrapping 00 -> max.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] maxv);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = maxv;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    // A mode press takes priority over an edit. Up and down pressed
    // together cancel each other out.
    assign w_any_btn = BTN_MODE | BTN_UP | BTN_DOWN;
    assign w_edit_up = BTN_UP   & ~BTN_DOWN & ~BTN_MODE;
    assign w_edit_dn = BTN_DOWN & ~BTN_UP   & ~BTN_MODE;

    always_comb begin
        state_d = state_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        idle_d  = idle_q;
        day_d   = 1'b0;

        if (state_q == c_ST_RUN) begin
            idle_d = 8'd0;
            if (TICK_1HZ) begin
                ss_d = bcd_inc(ss_q, c_SIX_MAX);
                if (ss_q == c_SIX_MAX) begin
                    mm_d = bcd_inc(mm_q, c_SIX_MAX);
                    if (mm_q == c_SIX_MAX) begin
                        hh_d = bcd_inc(hh_q, c_HOUR_BCD);
                        if (hh_q == c_HOUR_BCD) begin
                            day_d = 1'b1;
                        end
                    end
                end
            end
            if (BTN_MODE) begin
                state_d = c_ST_SET_HH;
            end
        end else begin
            // Set states: edits wrap within the field and never carry.
            case (state_q)
                c_ST_SET_HH: begin
                    if (w_edit_up) hh_d = bcd_inc(hh_q, c_HOUR_BCD);
                    if (w_edit_dn) hh_d = bcd_dec(hh_q, c_HOUR_BCD);
                end
                c_ST_SET_MM: begin
                    if (w_edit_up) mm_d = bcd_inc(mm_q, c_SIX_MAX);
                    if (w_edit_dn) mm_d = bcd_dec(mm_q, c_SIX_MAX);
                end
                default: begin
                    if (w_edit_up) ss_d = bcd_inc(ss_q, c_SIX_MAX);
                    if (w_edit_dn) ss_d = bcd_dec(ss_q, c_SIX_MAX);
                end
            endcase

            // A button in the same cycle as the final idle tick wins, so
            // the idle-timeout branch is only reached with no button.
            if (BTN_MODE) begin
                idle_d = 8'd0;
                case (state_q)
                    c_ST_SET_HH: state_d = c_ST_SET_MM;
                    c_ST_SET_MM: state_d = c_ST_SET_SS;
                    default:     state_d = c_ST_RUN;
                endcase
            end else if (w_any_btn) begin
                idle_d = 8'd0;
            end else if (TICK_1HZ) begin
                if (idle_q + 8'd1 == c_IDLE) begin
                    state_d = c_ST_RUN;
                    idle_d  = 8'd0;
                end else begin
                    idle_d  = idle_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= c_ST_RUN;
            hh_q    <= INIT_HH;
            mm_q    <= INIT_MM;
            ss_q    <= INIT_SS;
            idle_q  <= 8'd0;
            day_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            idle_q  <= idle_d;
            day_q   <= day_d;
        end
    end

    assign TIME_DATA = {8'h00, hh_q, mm_q, ss_q};
    assign EDIT_SEL  = state_q;
    assign DAY_PULSE = day_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_set_ctrl
// Purpose  : Self-checking bench for time_set_ctrl. It uses a table of
//            single-cycle vectors followed by hand-written multi-cycle
//            sequences for wrap, rollover, idle timeout and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;

    logic        CLK;
    logic        RESET;
    logic        TICK_1HZ;
    logic        BTN_MODE;
    logic        BTN_UP;
    logic        BTN_DOWN;
    logic [31:0] TIME_DATA;
    logic [1:0]  EDIT_SEL;
    logic        DAY_PULSE;

    int n_chk;
    int n_fail;

    time_set_ctrl dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .TICK_1HZ  (TICK_1HZ),
        .BTN_MODE  (BTN_MODE),
        .BTN_UP    (BTN_UP),
        .BTN_DOWN  (BTN_DOWN),
        .TIME_DATA (TIME_DATA),
        .EDIT_SEL  (EDIT_SEL),
        .DAY_PULSE (DAY_PULSE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        tick;
        logic        mode;
        logic        up;
        logic        down;
        logic [31:0] t;
        logic [1:0]  sel;
        logic        day;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [31:0] t, input logic [1:0] sel, input logic day);
        chk({name, ".time"}, TIME_DATA, t);
        chk({name, ".sel"}, {30'd0, EDIT_SEL}, {30'd0, sel});
        chk({name, ".day"}, {31'd0, DAY_PULSE}, {31'd0, day});
    endtask

    // Called at a falling edge. Inputs are held across one rising edge and
    // released at the next falling edge, where the outputs are sampled.
    task automatic cyc(input logic t, input logic m, input logic u, input logic d);
        TICK_1HZ = t;
        BTN_MODE = m;
        BTN_UP   = u;
        BTN_DOWN = d;
        @(negedge CLK);
        TICK_1HZ = 1'b0;
        BTN_MODE = 1'b0;
        BTN_UP   = 1'b0;
        BTN_DOWN = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        RESET    = 1'b1;
        TICK_1HZ = 1'b0;
        BTN_MODE = 1'b0;
        BTN_UP   = 1'b0;
        BTN_DOWN = 1'b0;

        //               tick  mode  up    down  time          sel    day
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0012_0001, 2'b00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0012_0002, 2'b00, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0012_0003, 2'b00, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0012_0003, 2'b00, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0012_0003, 2'b00, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0012_0004, 2'b01, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0013_0004, 2'b01, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0013_0004, 2'b01, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0013_0004, 2'b01, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0012_0004, 2'b01, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0012_0004, 2'b10, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0012_5904, 2'b10, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0012_0004, 2'b10, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0012_5904, 2'b10, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0012_5904, 2'b11, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0012_5903, 2'b11, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0012_5904, 2'b11, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0012_5904, 2'b11, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0012_5904, 2'b00, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0012_5905, 2'b00, 1'b0};

        @(negedge CLK);
        do_reset();
        chk_all("reset", 32'h0012_0000, 2'b00, 1'b0);

        for (int i = 0; i < 20; i++) begin
            cyc(vecs[i].tick, vecs[i].mode, vecs[i].up, vecs[i].down);
            chk_all($sformatf("vec%0d", i), vecs[i].t, vecs[i].sel, vecs[i].day);
        end

        // Hour wrap in both directions, then preload 23:59:59.
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("hh_up_wrap", 32'h0000_0000, 2'b01, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("hh_dn_wrap", 32'h0023_0000, 2'b01, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("hh_up_again", 32'h0000_0000, 2'b01, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("mm_dn_wrap", 32'h0023_5900, 2'b10, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("ss_dn_wrap", 32'h0023_5959, 2'b11, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("back_run", 32'h0023_5959, 2'b00, 1'b0);

        // Midnight rollover: DAY_PULSE is high for exactly one cycle.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("rollover", 32'h0000_0000, 2'b00, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("day_drop", 32'h0000_0000, 2'b00, 1'b0);

        // Carry from the low seconds digit into the high digit: 09 -> 10.
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("ss_09", 32'h0000_0009, 2'b00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("ss_10", 32'h0000_0010, 2'b00, 1'b0);

        // Idle timeout: nine ticks remain in SET_HH; the tenth returns to RUN.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("idle_9", 32'h0000_0010, 2'b01, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("idle_10", 32'h0000_0010, 2'b00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("no_catchup", 32'h0000_0011, 2'b00, 1'b0);

        // A button on the tenth idle tick wins and restarts the idle count.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("btn_wins", 32'h0001_0011, 2'b01, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("idle_restart", 32'h0001_0011, 2'b01, 1'b0);

        // Async reset in SET_SS, checked before the next rising edge.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("pre_async", 32'h0001_0011, 2'b11, 1'b0);
        @(posedge CLK);
        #3;
        RESET = 1'b0;
        #1;
        chk_all("async_rst", 32'h0012_0000, 2'b00, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk_all("post_rst", 32'h0012_0000, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
